// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants for the multi-cycle RV32 sequencer: state codes, PC/WB mux selects,
// the ecall word and the bundled decoder flags.
package mc_ctrl_fsm_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;

   localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
      logic branch;
      logic jump;
   } dec_flags_t;

   // IDLE, HALT and ERR are the only states where the core is not working on an instruction.
   function automatic logic is_busy(input logic [2:0] s);
      return (s != S_IDLE) && (s != S_HALT) && (s != S_ERR);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_bus_watchdog.sv
// Counts consecutive cycles a bus request waits for its ack and pulses timeout on the
// TIMEOUT_CYCLES-th unanswered request cycle.
module bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic ack,
   output logic timeout
);

   // cnt holds the number of earlier unanswered cycles, so the current cycle is cnt+1.
   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt;

   // An ack in the terminal cycle suppresses the timeout.
   assign timeout = req & ~ack & (cnt == LAST);

   // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (req & ~ack)
         cnt <= cnt + 1'b1;
      else
         cnt <= '0;
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: fetch, decode, execute, memory and writeback over shared
// IMEM/DMEM req/ack buses, with bus timeout, halt and cycle/instret counters.
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_o,
   input  logic        dec_memread,
   input  logic        dec_memwrite,
   input  logic        dec_regwrite,
   input  logic        dec_memtoreg,
   input  logic        dec_branch,
   input  logic        dec_jump,
   input  logic        br_cond,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        ex_en,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        busy_o,
   output logic        halted_o,
   output logic        err_o,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   logic [2:0]  state, state_nxt;
   logic [31:0] ir;
   logic        timeout;
   dec_flags_t  dec;

   assign dec = '{memread:  dec_memread,  memwrite: dec_memwrite,
                  regwrite: dec_regwrite, memtoreg: dec_memtoreg,
                  branch:   dec_branch,   jump:     dec_jump};

   // One watchdog serves both buses; only one request can be open at a time.
   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .req     (imem_req | dmem_req),
      .ack     ((imem_req & imem_ack) | (dmem_req & dmem_ack)),
      .timeout (timeout)
   );

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ex_en    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_SEQ;
      reg_we   = 1'b0;
      wb_sel   = WB_SEL_ALU;
      case (state)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            ex_en = 1'b1;
            if (!(dec.memread | dec.memwrite)) begin
               if (dec.branch) begin
                  pc_we  = 1'b1;
                  pc_sel = br_cond ? PC_SEL_BRANCH : PC_SEL_SEQ;
               end else if (!(dec.jump | dec.regwrite)) begin
                  pc_we = 1'b1;
               end
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec.memwrite;
            pc_we    = dmem_ack & ~dec.memread;
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_sel = dec.jump ? WB_SEL_PC4 : (dec.memtoreg ? WB_SEL_MEM : WB_SEL_ALU);
            pc_we  = 1'b1;
            pc_sel = dec.jump ? PC_SEL_JUMP : PC_SEL_SEQ;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack)     state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_ERR;
         end
         S_DECODE: state_nxt = (ir == ECALL_WORD) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (dec.memread | dec.memwrite)   state_nxt = S_MEM;
            else if (dec.branch)              state_nxt = S_FETCH;
            else if (dec.jump | dec.regwrite) state_nxt = S_WB;
            else                              state_nxt = S_FETCH;
         end
         S_MEM: begin
            if (dmem_ack)     state_nxt = dec.memread ? S_WB : S_FETCH;
            else if (timeout) state_nxt = S_ERR;
         end
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = state;
      endcase
   end

   assign busy_o   = is_busy(state);
   assign halted_o = (state == S_HALT);
   assign err_o    = (state == S_ERR);
   assign instr_o  = ir;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ir          <= '0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_FETCH) && imem_ack)
            ir <= imem_rdata;
         if (busy_o)
            cycle_cnt <= cycle_cnt + 32'd1;
         if (pc_we)
            instret_cnt <= instret_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed vector table, random instruction stream
// against a per-instruction latency model, and hand sequences for halt, timeout and reset.
module tb_mc_ctrl_fsm;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst, start, imem_ack, dmem_ack, br_cond;
   logic [31:0] imem_rdata;
   logic        dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg, dec_branch, dec_jump;
   logic        imem_req, dmem_req, dmem_we, ex_en, pc_we, reg_we, busy_o, halted_o, err_o;
   logic [1:0]  pc_sel, wb_sel;
   logic [31:0] instr_o, cycle_cnt, instret_cnt;
   logic [108:0] outs;

   mc_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_o(instr_o),
      .dec_memread(dec_memread), .dec_memwrite(dec_memwrite), .dec_regwrite(dec_regwrite),
      .dec_memtoreg(dec_memtoreg), .dec_branch(dec_branch), .dec_jump(dec_jump),
      .br_cond(br_cond), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ex_en(ex_en), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
      .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   assign outs = {imem_req, dmem_req, dmem_we, ex_en, pc_we, pc_sel, reg_we, wb_sel,
                  busy_o, halted_o, err_o, instr_o, cycle_cnt, instret_cnt};

   typedef enum int {K_NOP, K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_ECALL} kind_e;

   typedef struct packed {
      int cycles; int imem; int dmem; int dmem_we; int ex_en;
      int reg_we; int wb_sel; int pc_we; int pc_sel; int halted; int err;
   } res_t;

   typedef struct packed {
      kind_e kind; bit br; int iw; int dw; res_t exp;
   } vec_t;

   int     n_cmp = 0;
   int     n_err = 0;
   longint exp_cyc, exp_ret;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic res_t mk(int cyc, int im, int dm, int we, int ex, int rw, int wbs,
                               int pcw, int pcs, int h, int e);
      res_t r;
      r = '{cyc, im, dm, we, ex, rw, wbs, pcw, pcs, h, e};
      return r;
   endfunction

   function automatic logic [31:0] word_of(kind_e k);
      case (k)
         K_NOP:    return 32'h0000_0013;
         K_ALU:    return 32'h0020_81B3;
         K_LOAD:   return 32'h0000_A283;
         K_STORE:  return 32'h0020_A023;
         K_BRANCH: return 32'h0020_8463;
         K_JAL:    return 32'h0100_00EF;
         default:  return 32'h0000_0073;
      endcase
   endfunction

   // Expected per-instruction profile built from the phase rules: fetch waits iw cycles,
   // decode and execute take one each, memory waits dw cycles, writeback takes one.
   function automatic res_t model(kind_e k, bit br, int iw, int dw);
      res_t e;
      e = '0;
      e.imem   = iw + 1;
      e.cycles = iw + 2;
      if (k == K_ECALL) begin
         e.halted = 1;
         return e;
      end
      e.cycles += 1;
      e.ex_en   = 1;
      if (k == K_LOAD || k == K_STORE) begin
         e.dmem    = dw + 1;
         e.cycles += dw + 1;
         e.dmem_we = (k == K_STORE) ? 1 : 0;
      end
      if (k == K_LOAD || k == K_ALU || k == K_JAL) begin
         e.cycles += 1;
         e.reg_we  = 1;
         e.wb_sel  = (k == K_JAL) ? 2 : (k == K_LOAD) ? 1 : 0;
      end
      e.pc_we  = 1;
      e.pc_sel = (k == K_BRANCH) ? int'(br) : (k == K_JAL) ? 2 : 0;
      return e;
   endfunction

   task automatic set_flags(input kind_e k, input bit br);
      dec_memread  = (k == K_LOAD);
      dec_memwrite = (k == K_STORE);
      dec_regwrite = (k == K_LOAD) || (k == K_ALU) || (k == K_JAL);
      dec_memtoreg = (k == K_LOAD);
      dec_branch   = (k == K_BRANCH);
      dec_jump     = (k == K_JAL);
      br_cond      = br;
      imem_rdata   = word_of(k);
   endtask

   // Steps one instruction from its first FETCH cycle; returns at the cycle that retires it
   // (pc_we) or at the first HALT/ERR cycle.
   task automatic run_instr(input kind_e k, input bit br, input int iw, input int dw,
                            output res_t r, output longint cyc0, output longint ret0);
      int ic, dc;
      bit done;
      r = '0; ic = 0; dc = 0; done = 0; cyc0 = 0; ret0 = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 0) set_flags(k, br);
         imem_ack = imem_req && (ic == iw);
         if (imem_req) ic++;
         dmem_ack = dmem_req && (dc == dw);
         if (dmem_req) dc++;
         #1;
         if (c == 0) begin
            cyc0 = cycle_cnt;
            ret0 = instret_cnt;
         end
         if (busy_o)   r.cycles++;
         if (imem_req) r.imem++;
         if (dmem_req) begin
            r.dmem++;
            if (dmem_we) r.dmem_we = 1;
         end
         if (ex_en)    r.ex_en++;
         if (reg_we) begin
            r.reg_we++;
            r.wb_sel = int'(wb_sel);
         end
         if (pc_we) begin
            r.pc_we++;
            r.pc_sel = int'(pc_sel);
            done = 1;
         end
         if (halted_o) begin r.halted = 1; done = 1; end
         if (err_o)    begin r.err = 1;    done = 1; end
      end
      if (!done) check("instr_cycle_budget", 0, 1);
   endtask

   task automatic compare(input string tag, input res_t a, input res_t e);
      check({tag, ".cycles"},  a.cycles,  e.cycles);
      check({tag, ".imem"},    a.imem,    e.imem);
      check({tag, ".dmem"},    a.dmem,    e.dmem);
      check({tag, ".dmem_we"}, a.dmem_we, e.dmem_we);
      check({tag, ".ex_en"},   a.ex_en,   e.ex_en);
      check({tag, ".reg_we"},  a.reg_we,  e.reg_we);
      check({tag, ".wb_sel"},  a.wb_sel,  e.wb_sel);
      check({tag, ".pc_we"},   a.pc_we,   e.pc_we);
      check({tag, ".pc_sel"},  a.pc_sel,  e.pc_sel);
      check({tag, ".halted"},  a.halted,  e.halted);
      check({tag, ".err"},     a.err,     e.err);
   endtask

   // Runs one instruction, checks the counters at its first cycle, its profile and the IR.
   task automatic exec_and_check(input string tag, input kind_e k, input bit br,
                                 input int iw, input int dw, input res_t e);
      res_t   r;
      longint c0, r0;
      run_instr(k, br, iw, dw, r, c0, r0);
      check({tag, ".cycle_cnt"},   c0, exp_cyc);
      check({tag, ".instret_cnt"}, r0, exp_ret);
      compare(tag, r, e);
      check({tag, ".ir"}, instr_o, word_of(k));
      exp_cyc += e.cycles;
      exp_ret += e.pc_we;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_cpu();
      @(negedge clk);
      start = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t   vecs[7];
      res_t   r;
      longint c0, r0;
      kind_e  k;
      bit     br, seen;
      int     iw, dw;

      rst = 1'b1; start = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF; br_cond = 1'b0;
      dec_memread = 0; dec_memwrite = 0; dec_regwrite = 0;
      dec_memtoreg = 0; dec_branch = 0; dec_jump = 0;

      //            kind      br    iw dw   cyc imem dmem we ex rw wbs pcw pcs h  e
      vecs[0] = '{K_ALU,    1'b0, 0, 0, mk(4,  1,   0,  0, 1, 1, 0,  1,  0,  0, 0)};
      vecs[1] = '{K_LOAD,   1'b0, 0, 3, mk(8,  1,   4,  0, 1, 1, 1,  1,  0,  0, 0)};
      vecs[2] = '{K_BRANCH, 1'b1, 0, 0, mk(3,  1,   0,  0, 1, 0, 0,  1,  1,  0, 0)};
      vecs[3] = '{K_BRANCH, 1'b0, 2, 0, mk(5,  3,   0,  0, 1, 0, 0,  1,  0,  0, 0)};
      vecs[4] = '{K_JAL,    1'b0, 0, 0, mk(4,  1,   0,  0, 1, 1, 2,  1,  2,  0, 0)};
      vecs[5] = '{K_STORE,  1'b0, 0, 0, mk(4,  1,   1,  1, 1, 0, 0,  1,  0,  0, 0)};
      vecs[6] = '{K_NOP,    1'b0, 1, 0, mk(4,  2,   0,  0, 1, 0, 0,  1,  0,  0, 0)};

      // Reset with stale acks present, then IDLE must ignore them.
      repeat (2) @(negedge clk);
      #1 check("reset_outputs", outs, 0);
      rst = 1'b0;
      @(negedge clk);
      #1 check("idle_stale_ack", outs, 0);
      imem_ack = 1'b0; dmem_ack = 1'b0;

      exp_cyc = 0; exp_ret = 0;
      start_cpu();
      for (int i = 0; i < 7; i++)
         exec_and_check($sformatf("vec%0d", i), vecs[i].kind, vecs[i].br,
                        vecs[i].iw, vecs[i].dw, vecs[i].exp);

      for (int i = 0; i < 40; i++) begin
         k  = kind_e'($urandom_range(5, 0));
         br = 1'($urandom_range(1, 0));
         iw = $urandom_range(4, 0);
         dw = $urandom_range(4, 0);
         exec_and_check($sformatf("rnd%0d", i), k, br, iw, dw, model(k, br, iw, dw));
      end

      // ecall halts without retiring; afterwards start and acks are ignored.
      exec_and_check("ecall", K_ECALL, 1'b0, 1, 0, model(K_ECALL, 1'b0, 1, 0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
         #1 check($sformatf("halt_hold%0d", i),
                  {halted_o, err_o, busy_o, imem_req, dmem_req, pc_we, reg_we, ex_en}, 8'b1000_0000);
      end
      check("halt_cycle_frozen",   cycle_cnt,   exp_cyc);
      check("halt_instret_frozen", instret_cnt, exp_ret);

      // Fetch with no ack: ERR after TO request cycles, request dropped afterwards.
      do_reset();
      start_cpu();
      run_instr(K_ALU, 1'b0, 1000, 0, r, c0, r0);
      compare("timeout", r, mk(TO, TO, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      check("timeout_cycle_cnt",   cycle_cnt,   TO);
      check("timeout_instret_cnt", instret_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         imem_ack = 1'b0; start = 1'b1;
         #1 check($sformatf("err_hold%0d", i), {err_o, imem_req, busy_o}, 3'b100);
      end

      // Ack on the terminal cycle wins over the timeout.
      do_reset();
      exp_cyc = 0; exp_ret = 0;
      start_cpu();
      exec_and_check("ack_at_limit", K_ALU, 1'b0, TO - 1, 0, model(K_ALU, 1'b0, TO - 1, 0));

      // Reset while a load waits in MEM; the late ack after reset is ignored.
      do_reset();
      start_cpu();
      @(negedge clk);
      start = 1'b0;
      set_flags(K_LOAD, 1'b0);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         imem_ack = imem_req;
         if (dmem_req) seen = 1;
         else @(negedge clk);
      end
      imem_ack = 1'b0;
      check("mem_wait_reached", seen, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; dmem_ack = 1'b1;
      #1 check("rst_in_mem", outs, 0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1 check("late_dmem_ack_ignored", outs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
